// File: rtl/traffic_pkg.sv
// Shared phase numbering, controller state encoding and default timing for
// the intersection phase scheduler.
package traffic_pkg;

    localparam logic [1:0] PH_NS_LEFT     = 2'd0;
    localparam logic [1:0] PH_NS_STRAIGHT = 2'd1;
    localparam logic [1:0] PH_EW_LEFT     = 2'd2;
    localparam logic [1:0] PH_EW_STRAIGHT = 2'd3;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        REST   = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } state_t;

    localparam int DEF_T_MIN_GREEN = 20;
    localparam int DEF_T_MAX_GREEN = 60;
    localparam int DEF_T_YELLOW    = 10;
    localparam int DEF_T_ALL_RED   = 5;
    localparam int DEF_CW          = 8;

    function automatic logic [3:0] phase_mask(input logic [1:0] p);
        phase_mask = 4'b0001 << p;
    endfunction

endpackage

// File: rtl/phase_rr_picker.sv
// Round-robin search for the next phase with an outstanding request,
// starting just after the current phase and ending on the current phase.
module phase_rr_picker
    import traffic_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] cur_phase,
    output logic [1:0] next_phase,
    output logic       found
);

    always_comb begin
        next_phase = cur_phase;
        found      = 1'b0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = 4; k >= 1; k--) begin
            if (pending[cur_phase + 2'(k)]) begin
                next_phase = cur_phase + 2'(k);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-phase intersection sequencer with green extension,
// max-out and emergency preemption; all outputs are registered.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int CW          = DEF_CW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       preempt_req,
    input  logic [1:0] preempt_phase,
    output logic [3:0] green,
    output logic [3:0] amber,
    output logic       all_red,
    output logic [1:0] cur_phase,
    output logic       phase_start,
    output logic [3:0] pending
);

    localparam logic [CW:0] MIN_G  = (CW+1)'(T_MIN_GREEN);
    localparam logic [CW:0] MAX_G  = (CW+1)'(T_MAX_GREEN);
    localparam logic [CW:0] YEL_T  = (CW+1)'(T_YELLOW);
    localparam logic [CW:0] CLR_T  = (CW+1)'(T_ALL_RED);

    state_t        state, state_nxt;
    logic [CW-1:0] timer;
    logic [CW:0]   elapsed;
    logic [1:0]    phase_nxt;
    logic [1:0]    rr_phase;
    logic          rr_found;
    logic          grant;
    logic          other;
    logic [3:0]    pending_nxt;

    phase_rr_picker u_picker (
        .pending    (pending),
        .cur_phase  (cur_phase),
        .next_phase (rr_phase),
        .found      (rr_found)
    );

    always_comb begin
        state_nxt   = state;
        phase_nxt   = cur_phase;
        grant       = 1'b0;
        elapsed     = {1'b0, timer} + (CW+1)'(1);
        other       = |(pending & ~phase_mask(cur_phase));
        pending_nxt = pending | (req & ~green);

        case (state)
            CLEAR, REST: begin
                if (state == REST || elapsed == CLR_T) begin
                    state_nxt = REST;
                    if (preempt_req) begin
                        grant     = 1'b1;
                        phase_nxt = preempt_phase;
                    end else if (rr_found) begin
                        grant     = 1'b1;
                        phase_nxt = rr_phase;
                    end
                end
            end
            GREEN: begin
                // A preempt for the phase already green simply holds it.
                if (preempt_req) begin
                    if (preempt_phase != cur_phase)
                        state_nxt = YELLOW;
                end else if (other && elapsed >= MIN_G &&
                             (!req[cur_phase] || elapsed >= MAX_G)) begin
                    state_nxt = YELLOW;
                end
            end
            YELLOW: begin
                if (elapsed == YEL_T)
                    state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase

        if (grant) begin
            state_nxt   = GREEN;
            pending_nxt = pending_nxt & ~phase_mask(phase_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CLEAR;
            timer       <= '0;
            green       <= '0;
            amber       <= '0;
            all_red     <= 1'b1;
            cur_phase   <= 2'd3;
            phase_start <= 1'b0;
            pending     <= '0;
        end else begin
            state       <= state_nxt;
            // Saturate so an indefinitely resting green never wraps.
            if (state_nxt != state)
                timer <= '0;
            else if (!(&timer))
                timer <= timer + CW'(1);
            cur_phase   <= phase_nxt;
            pending     <= pending_nxt;
            phase_start <= grant;
            green       <= (state_nxt == GREEN)  ? phase_mask(phase_nxt) : 4'b0000;
            amber       <= (state_nxt == YELLOW) ? phase_mask(phase_nxt) : 4'b0000;
            all_red     <= !(state_nxt == GREEN || state_nxt == YELLOW);
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed scenarios plus random
// demand/preemption, checked against an interval-level reference model.
module tb_traffic_phase_scheduler;

    localparam int TMIN = 4;
    localparam int TMAX = 12;
    localparam int TY   = 3;
    localparam int TAR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0;
    logic       preempt_req = 1'b0;
    logic [1:0] preempt_phase = 2'd0;
    logic [3:0] green, amber, pending;
    logic       all_red, phase_start;
    logic [1:0] cur_phase;

    traffic_phase_scheduler #(
        .T_MIN_GREEN (TMIN),
        .T_MAX_GREEN (TMAX),
        .T_YELLOW    (TY),
        .T_ALL_RED   (TAR),
        .CW          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .preempt_req   (preempt_req),
        .preempt_phase (preempt_phase),
        .green         (green),
        .amber         (amber),
        .all_red       (all_red),
        .cur_phase     (cur_phase),
        .phase_start   (phase_start),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] a;
        logic       ar;
        logic [1:0] cp;
        logic       ps;
        logic [3:0] pd;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    // Reference model: interval kind, cycles already spent in it, served phase.
    localparam int I_CLEAR = 0, I_REST = 1, I_GREEN = 2, I_AMBER = 3;
    int       m_kind, m_age, m_ph;
    bit [3:0] m_pend;
    bit       m_start;

    function automatic int rr_pick(input bit [3:0] p, input int from);
        for (int k = 1; k <= 4; k++)
            if (p[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_kind = I_CLEAR; m_age = 0; m_ph = 3; m_pend = 4'b0; m_start = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic pq, input logic [1:0] pp);
        bit [3:0] np;
        int nk, gnt, done;
        bit others;
        np = m_pend;
        for (int i = 0; i < 4; i++)
            if (r[i] && !(m_kind == I_GREEN && m_ph == i)) np[i] = 1'b1;
        others = 0;
        for (int j = 0; j < 4; j++)
            if (j != m_ph && m_pend[j]) others = 1;
        done = m_age + 1;
        nk = m_kind;
        gnt = -1;
        if (m_kind == I_REST || (m_kind == I_CLEAR && done == TAR)) begin
            nk  = I_REST;
            gnt = pq ? int'(pp) : rr_pick(m_pend, m_ph);
        end else if (m_kind == I_GREEN) begin
            if (pq) begin
                if (int'(pp) != m_ph) nk = I_AMBER;
            end else if (others && done >= TMIN && (!r[m_ph] || done >= TMAX)) begin
                nk = I_AMBER;
            end
        end else if (m_kind == I_AMBER && done == TY) begin
            nk = I_CLEAR;
        end
        m_start = (gnt >= 0);
        if (gnt >= 0) begin
            nk = I_GREEN;
            m_ph = gnt;
            np[gnt] = 1'b0;
        end
        m_age  = (nk == m_kind) ? m_age + 1 : 0;
        m_kind = nk;
        m_pend = np;
    endtask

    // Drive one cycle of inputs, queue the model's post-edge outputs, and
    // return just after that edge with DUT outputs settled.
    task automatic cyc(input logic [3:0] r, input logic pq, input logic [1:0] pp);
        exp_t e;
        req = r; preempt_req = pq; preempt_phase = pp;
        model_step(r, pq, pp);
        e.g  = (m_kind == I_GREEN) ? 4'(1 << m_ph) : 4'b0;
        e.a  = (m_kind == I_AMBER) ? 4'(1 << m_ph) : 4'b0;
        e.ar = !(m_kind == I_GREEN || m_kind == I_AMBER);
        e.cp = 2'(m_ph);
        e.ps = m_start;
        e.pd = m_pend;
        exp_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("green", green, e.g);
                chk("amber", amber, e.a);
                chk("all_red", all_red, e.ar);
                chk("cur_phase", cur_phase, e.cp);
                chk("phase_start", phase_start, e.ps);
                chk("pending", pending, e.pd);
                chk("one_lamp", ($countones(green | amber) <= 1), 1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, k, cnt, amb, seen;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        chk("rst_green", green, 0);
        chk("rst_amber", amber, 0);
        chk("rst_all_red", all_red, 1);
        chk("rst_cur_phase", cur_phase, 3);
        chk("rst_pending", pending, 0);
        rst = 1'b1;

        // Idle after reset: stays all red.
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, 0, 0);
            chk("idle_all_red", all_red, 1);
        end

        // Skip and order: phases 1 and 3 only.
        cyc(4'b1010, 0, 0);
        cnt = 0; amb = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0000, 0, 0);
            if (green[1]) cnt++;
            if (amber[1]) amb++;
            if (green[0] || green[2]) seen++;
        end
        chk("skip_green1_len", cnt, TMIN);
        chk("skip_amber1_len", amb, TY);
        chk("skip_no_0_2", seen, 0);
        chk("skip_then_green3", green, 4'b1000);

        // Extension to max-out.
        n = 0;
        while (!green[0] && n < 30) begin cyc(4'b0001, 0, 0); n++; end
        chk("ext_got_green0", green[0], 1);
        cnt = 0;
        while (green[0] && cnt < 40) begin
            cnt++;
            cyc((cnt == 1) ? 4'b0101 : 4'b0001, 0, 0);
        end
        chk("maxout_len", cnt, TMAX);

        // Extension ended by dropping the request during cycle 6.
        n = 0;
        while (!green[0] && n < 60) begin cyc(4'b0001, 0, 0); n++; end
        chk("ext2_got_green0", green[0], 1);
        cnt = 0;
        while (green[0] && cnt < 40) begin
            cnt++;
            cyc({1'b0, (cnt == 1), 1'b0, (cnt < 6)}, 0, 0);
        end
        chk("drop_len", cnt, 6);

        // Rest in green with only phase 1 requested.
        for (int i = 0; i < 40; i++) cyc(4'b0000, 0, 0);
        n = 0;
        while (!green[1] && n < 40) begin cyc(4'b0010, 0, 0); n++; end
        chk("rest_got_green1", green[1], 1);
        cnt = 0; amb = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(4'b0010, 0, 0);
            if (green[1]) cnt++;
            if (amber != 0) amb++;
        end
        chk("rest_green_len", cnt, 100);
        chk("rest_no_amber", amb, 0);

        // Preemption to phase 3 while phase 0 is freshly green.
        n = 0;
        while (!green[0] && n < 30) begin cyc(4'b0001, 0, 0); n++; end
        chk("pre_got_green0", green[0], 1);
        cyc(4'b0010, 0, 0);
        cyc(4'b0000, 1, 2'd3);
        chk("pre_amber_next", amber, 4'b0001);
        k = 0;
        while (amber[0] && k < 10) begin k++; cyc(4'b0000, 1, 2'd3); end
        chk("pre_amber_len", k, TY);
        k = 0;
        while (all_red && k < 10) begin k++; cyc(4'b0000, 1, 2'd3); end
        chk("pre_clear_len", k, TAR);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (green[3]) cnt++;
            cyc(4'b0000, 1, 2'd3);
        end
        chk("pre_hold_len", cnt, 20);
        chk("pre_pending1_kept", pending[1], 1);
        n = 0;
        while (!green[1] && n < 30) begin cyc(4'b0000, 0, 0); n++; end
        chk("post_pre_green1", green[1], 1);

        // Asynchronous reset in the middle of an amber.
        n = 0;
        while (amber == 0 && n < 30) begin cyc(4'b0100, 0, 0); n++; end
        chk("yel_before_reset", amber, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_green", green, 0);
        chk("arst_amber", amber, 0);
        chk("arst_all_red", all_red, 1);
        chk("arst_pending", pending, 0);
        chk("arst_cur_phase", cur_phase, 3);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;

        // Random demand and preemption episodes.
        begin
            logic [3:0] r;
            logic       pq;
            logic [1:0] pp;
            pq = 0; pp = 0;
            for (int i = 0; i < 1500; i++) begin
                for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    pq = ~pq;
                    if (pq) pp = 2'($urandom_range(0, 3));
                end
                cyc(r, pq, pp);
            end
        end

        cyc(4'b0000, 0, 0);
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven phase sequencer for the 4-way intersection.
- Four phases, in fixed round-robin order: 0 = NS left, 1 = NS straight, 2 = EW left, 3 = EW straight.
- Serves phases from latched vehicle-detector requests and skips phases with no demand.
- Extends green between min and max limits; supports emergency preemption.
- Drives one-hot green and amber phase commands, which feed the lamp-driver stage.

Parameters:
- T_MIN_GREEN, 20, minimum green cycles per served phase (>=1).
- T_MAX_GREEN, 60, maximum green cycles while another phase is pending (>= T_MIN_GREEN).
- T_YELLOW, 10, amber cycles (>=1).
- T_ALL_RED, 5, all-red clearance cycles (>=1).
- CW, 8, timer width; must hold T_MAX_GREEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  4  detector requests, one bit per phase, level or pulse.
- preempt_req  in  1  emergency preemption request, level.
- preempt_phase  in  2  phase to force while preempt_req=1.
- green  out  4  one-hot green command per phase, or 0.
- amber  out  4  one-hot amber command per phase, or 0.
- all_red  out  1  no phase green or amber.
- cur_phase  out  2  phase most recently granted.
- phase_start  out  1  one-cycle pulse on the first green cycle of a phase.
- pending  out  4  latched outstanding requests, for debug.

Behaviour:
- Clock and reset:
  - Single clock; all outputs registered.
  - Reset values: state=CLEAR, timer=0, green=0, amber=0, all_red=1, cur_phase=3, phase_start=0, pending=0.
  - The round-robin pointer resets to 3, so phase 0 is served first.
- States: CLEAR (all-red clearance), REST (all red, no demand), GREEN, YELLOW.
  - The timer resets to 0 on every state entry and counts cycles spent in the state.
- Request latching:
  - pending[i] is set when req[i]=1 and phase i is not currently green.
  - pending[i] is cleared on the cycle GREEN for phase i is entered; a set and clear in the same cycle resolves to clear.
- Next phase: first i with pending[i]=1, searching cur_phase+1, +2, +3, +0 (modulo 4).
- CLEAR:
  - Lasts exactly T_ALL_RED cycles.
  - Then: if preempt_req=1, go to GREEN(preempt_phase); else if any pending, go to GREEN(next); else go to REST.
- REST: all_red=1. Leave on the first cycle with preempt_req or any pending; GREEN starts the next cycle.
- GREEN:
  - green[cur_phase]=1; phase_start=1 on the first cycle only.
  - Let e = completed green cycles and other = any pending[j] with j != cur_phase.
  - Terminate to YELLOW when other=1 and e >= T_MIN_GREEN and (req[cur_phase]=0 or e >= T_MAX_GREEN).
  - With other=0 the phase rests in green indefinitely; T_MAX_GREEN does not apply.
- YELLOW: amber[cur_phase]=1 for exactly T_YELLOW cycles, then CLEAR.
- Preemption:
  - In GREEN with preempt_req=1 and preempt_phase != cur_phase: terminate to YELLOW immediately, ignoring T_MIN_GREEN.
  - In GREEN with preempt_phase == cur_phase: hold green while preempt_req=1, ignoring T_MAX_GREEN.
  - In YELLOW or CLEAR: complete the current interval in full; there are never shortened ambers or clearances.
  - The preempted phase's pending bit is cleared on entry like a normal grant. Pending bits of other phases are preserved.
  - After preempt_req drops, normal round-robin resumes from preempt_phase.
- Invariants:
  - At most one bit set across green|amber.
  - all_red = ~|(green|amber).
  - Every green-to-other-green transition passes through T_YELLOW amber cycles and then T_ALL_RED all-red cycles.
- Reset mid-operation forces reset values immediately, asynchronously; pending requests are discarded.

Decomposition:
- Shared package traffic_pkg holds:
  - phase constants PH_NS_LEFT=0, PH_NS_STRAIGHT=1, PH_EW_LEFT=2, PH_EW_STRAIGHT=3;
  - the state encoding (CLEAR, REST, GREEN, YELLOW);
  - default timing constants.
- One combinational sub-module, phase_rr_picker: inputs pending[3:0] and cur_phase; outputs next_phase[1:0] and found.

Test Plan:
- Bench overrides T_MIN_GREEN=4, T_MAX_GREEN=12, T_YELLOW=3, T_ALL_RED=2.
- Reset and idle: hold rst=0 for 3 cycles, release with req=0 -> all_red=1 throughout; state reaches REST after 2 cycles; green and amber stay 0.
- Skip and order: pulse req=4'b1010 in REST -> phase 1 green (phase_start pulse) for 4 cycles, amber[1] 3 cycles, all-red 2 cycles, then green[3]; phases 0 and 2 never granted.
- Extension and max-out: phase 0 green, hold req[0]=1, pulse req[2] -> green[0] lasts exactly 12 cycles. Repeat with req[0] dropped at cycle 6 -> green lasts 6 cycles.
- Rest in green: only req[1] ever asserted -> green[1] stays on for 100 cycles with no amber.
- Preemption: phase 0 green at e=1, preempt_req=1 with preempt_phase=3 -> amber[0] next cycle for 3 cycles, 2 all-red cycles, green[3] held while preempt_req=1 beyond 12 cycles. pending[1], set before preemption, is served after preempt_req drops.
- Async reset mid-YELLOW: drop rst between clock edges -> green=0, amber=0, all_red=1 immediately; pending=0.
